// File: rtl/alu_seq_pkg.sv
`default_nettype none
//==============================================================================
// Module   : alu_pkg
// Purpose  : Shared definitions for the alu_seq block: opcode encoding, flag
//            bit positions inside the 5-bit flags register, FSM state
//            encoding, and a helper that packs individual flag bits.
// Ports    : none (package)
// Revision : 1.0 - initial release
//==============================================================================
package alu_pkg;

    // Opcode encoding; 13..15 are reserved (result 0, flags untouched).
    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_NOT   = 4'd5,
        OP_LSH   = 4'd6,
        OP_ASH   = 4'd7,
        OP_ADDC  = 4'd8,
        OP_SUBC  = 4'd9,
        OP_CMP   = 4'd10,
        OP_LSR   = 4'd11,
        OP_MUL   = 4'd12,
        OP_RSV13 = 4'd13,
        OP_RSV14 = 4'd14,
        OP_RSV15 = 4'd15
    } alu_op_e;

    // Flags register layout: {C, L, F, Z, N}
    localparam int unsigned c_FLAGS_W = 5;
    localparam int unsigned c_FLAG_C  = 4;
    localparam int unsigned c_FLAG_L  = 3;
    localparam int unsigned c_FLAG_F  = 2;
    localparam int unsigned c_FLAG_Z  = 1;
    localparam int unsigned c_FLAG_N  = 0;

    // Control FSM: IDLE accepts requests, MUL runs the iterative multiplier.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } alu_state_e;

    function automatic logic [c_FLAGS_W-1:0] pack_flags(
        input logic c,
        input logic l,
        input logic f,
        input logic z,
        input logic n
    );
        logic [c_FLAGS_W-1:0] v;
        v           = '0;
        v[c_FLAG_C] = c;
        v[c_FLAG_L] = l;
        v[c_FLAG_F] = f;
        v[c_FLAG_Z] = z;
        v[c_FLAG_N] = n;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_mul_iter.sv
`default_nettype none
//==============================================================================
// Module   : alu_mul_iter
// Purpose  : Unsigned iterative shift-add multiplier, one multiplier bit per
//            clock, DATA_WIDTH iterations after the loading edge.
// Ports    : clk, reset   - clock, asynchronous active-high reset
//            start        - load operands (ignored while a product is running)
//            a, b         - multiplicand / multiplier
//            product      - full 2*DATA_WIDTH product, valid while done=1
//            done         - high in the cycle whose edge performs the final
//                           iteration; product already includes that step
// Revision : 1.0 - initial release
//==============================================================================
module alu_mul_iter #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [DATA_WIDTH-1:0]   a,
    input  logic [DATA_WIDTH-1:0]   b,
    output logic [2*DATA_WIDTH-1:0] product,
    output logic                    done
);
    localparam int c_CNT_W = $clog2(DATA_WIDTH);

    logic                  r_run;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [DATA_WIDTH-1:0] r_mcand;
    logic [DATA_WIDTH-1:0] r_hi;
    logic [DATA_WIDTH-1:0] r_lo;

    logic [DATA_WIDTH:0]     w_sum;
    logic [2*DATA_WIDTH-1:0] w_next;

    // Classic right-shifting accumulator: the multiplier occupies the low
    // half and is consumed LSB first while partial sums enter from the top.
    assign w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : '0);
    assign w_next = {w_sum, r_lo[DATA_WIDTH-1:1]};

    assign done    = r_run && (r_cnt == c_CNT_W'(DATA_WIDTH - 1));
    assign product = w_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_run   <= 1'b0;
            r_cnt   <= '0;
            r_mcand <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else if (r_run) begin
            {r_hi, r_lo} <= w_next;
            r_cnt        <= r_cnt + c_CNT_W'(1);
            if (done) begin
                r_run <= 1'b0;
            end
        end else if (start) begin
            r_run   <= 1'b1;
            r_cnt   <= '0;
            r_mcand <= a;
            r_hi    <= '0;
            r_lo    <= b;
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
//==============================================================================
// Module   : alu_seq
// Purpose  : Sequential ALU. Single-cycle arithmetic/logic/shift ops complete
//            one cycle after acceptance; MUL (when built in) runs on an
//            iterative multiplier and completes DATA_WIDTH+1 cycles later.
// Macro    : ALU_SEQ_MUL_EN - when defined, opcode 12 is an unsigned multiply;
//            when undefined, opcode 12 behaves as a reserved opcode and busy
//            is constant 0.
// Ports    : clk, reset   - clock, asynchronous active-high reset
//            start        - request, accepted in IDLE
//            op           - 4-bit opcode (see alu_pkg::alu_op_e)
//            a, b         - operands; b[SHAMT_W-1:0] is the shift amount
//            flag_we      - commit flags when the operation completes
//            busy         - multiply in progress, start ignored
//            done         - one-cycle completion pulse
//            result       - last result, held until the next done
//            flags        - {C, L, F, Z, N}
// Revision : 1.0 - initial release
//==============================================================================
module alu_seq
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [3:0]            op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  flag_we,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic [c_FLAGS_W-1:0]  flags
);
    localparam int c_MSB = DATA_WIDTH - 1;

    alu_state_e            r_state;
    alu_state_e            w_state_nxt;
    logic [DATA_WIDTH-1:0] r_result;
    logic [c_FLAGS_W-1:0]  r_flags;
    logic                  r_done;

    logic                  w_accept;
    logic                  w_is_mul;
    logic                  w_mul_done;
    logic [SHAMT_W-1:0]    w_shamt;
    logic                  w_cin;
    logic [DATA_WIDTH:0]   w_add_full;
    logic [DATA_WIDTH:0]   w_sub_full;
    logic [DATA_WIDTH-1:0] w_val;
    logic                  w_c;
    logic                  w_f;
    logic                  w_l;
    logic                  w_res_we;
    logic                  w_flag_ok;
    logic [c_FLAGS_W-1:0]  w_flags_new;

    assign w_accept = start && (r_state == ST_IDLE);
    assign w_shamt  = b[SHAMT_W-1:0];
    assign w_cin    = r_flags[c_FLAG_C];

    // Carry/borrow come out of bit DATA_WIDTH of a zero-extended add/sub;
    // the carry-in is only consumed by the ...C variants.
    assign w_add_full = {1'b0, a} + {1'b0, b}
                      + {{DATA_WIDTH{1'b0}}, ((op == OP_ADDC) & w_cin)};
    assign w_sub_full = {1'b0, a} - {1'b0, b}
                      - {{DATA_WIDTH{1'b0}}, ((op == OP_SUBC) & w_cin)};

    //--------------------------------------------------------------------------
    // Single-cycle datapath
    //--------------------------------------------------------------------------
    always_comb begin
        w_val     = '0;
        w_c       = 1'b0;
        w_f       = 1'b0;
        w_res_we  = 1'b1;
        w_flag_ok = 1'b1;
        case (op)
            OP_ADD, OP_ADDC: begin
                w_val = w_add_full[c_MSB:0];
                w_c   = w_add_full[DATA_WIDTH];
                w_f   = (a[c_MSB] == b[c_MSB]) && (w_val[c_MSB] != a[c_MSB]);
            end
            OP_SUB, OP_SUBC, OP_CMP: begin
                w_val    = w_sub_full[c_MSB:0];
                w_c      = w_sub_full[DATA_WIDTH];
                w_f      = (a[c_MSB] != b[c_MSB]) && (w_val[c_MSB] != a[c_MSB]);
                // CMP only reports flags; the visible result is left alone.
                w_res_we = (op != OP_CMP);
            end
            OP_AND: w_val = a & b;
            OP_OR:  w_val = a | b;
            OP_XOR: w_val = a ^ b;
            OP_NOT: w_val = ~a;
            OP_LSH: w_val = a << w_shamt;
            OP_ASH: w_val = $unsigned($signed(a) >>> w_shamt);
            OP_LSR: w_val = a >> w_shamt;
            default: begin
                // Reserved opcodes (and MUL in builds without a multiplier).
                w_val     = '0;
                w_flag_ok = 1'b0;
            end
        endcase
        w_l         = $signed(a) < $signed(b);
        w_flags_new = pack_flags(w_c, w_l, w_f, (w_val == '0), w_val[c_MSB]);
    end

    //--------------------------------------------------------------------------
    // Optional multiplier
    //--------------------------------------------------------------------------
`ifdef ALU_SEQ_MUL_EN
    logic [2*DATA_WIDTH-1:0] w_product;
    logic                    w_mul_start;
    logic                    r_mul_fwe;

    assign w_is_mul    = (op == OP_MUL);
    assign w_mul_start = w_accept && w_is_mul;
    assign busy        = (r_state == ST_MUL);

    alu_mul_iter #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (w_mul_start),
        .a       (a),
        .b       (b),
        .product (w_product),
        .done    (w_mul_done)
    );
`else
    assign w_is_mul   = 1'b0;
    assign w_mul_done = 1'b0;
    assign busy       = 1'b0;
`endif

    //--------------------------------------------------------------------------
    // Control FSM
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept && w_is_mul) w_state_nxt = ST_MUL;
            ST_MUL:  if (w_mul_done)           w_state_nxt = ST_IDLE;
            default:                           w_state_nxt = ST_IDLE;
        endcase
    end

    //--------------------------------------------------------------------------
    // Result / flags / done registers
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_result  <= '0;
            r_flags   <= '0;
            r_done    <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            r_mul_fwe <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            if (w_accept && !w_is_mul) begin
                r_done <= 1'b1;
                if (w_res_we) begin
                    r_result <= w_val;
                end
                if (flag_we && w_flag_ok) begin
                    r_flags <= w_flags_new;
                end
            end
`ifdef ALU_SEQ_MUL_EN
            // flag_we belongs to the request, so hold it for the whole run.
            if (w_mul_start) begin
                r_mul_fwe <= flag_we;
            end
            if (w_mul_done) begin
                r_done   <= 1'b1;
                r_result <= w_product[c_MSB:0];
                if (r_mul_fwe) begin
                    r_flags <= pack_flags(|w_product[2*DATA_WIDTH-1:DATA_WIDTH],
                                          1'b0, 1'b0,
                                          (w_product[c_MSB:0] == '0),
                                          w_product[c_MSB]);
                end
            end
`endif
        end
    end

    assign done   = r_done;
    assign result = r_result;
    assign flags  = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
//==============================================================================
// Module   : tb_alu_seq
// Purpose  : Self-checking bench for alu_seq (DATA_WIDTH=16). A behavioural
//            reference model tracks result/flags/done/busy from the opcode
//            rules using plain integer arithmetic; a compare process checks
//            every cycle, and literal expectations pin key vectors.
// Revision : 1.0 - initial release
//==============================================================================
module tb_alu_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        flag_we;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic [4:0]  flags;

    int n_cmp = 0;
    int n_bad = 0;
    bit checking = 1'b0;

`ifdef ALU_SEQ_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    alu_seq #(.DATA_WIDTH(16)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .flag_we (flag_we),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .flags   (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    //--------------------------------------------------------------------------
    // Reference model
    //--------------------------------------------------------------------------
    typedef struct packed {
        logic [15:0] res;
        logic [4:0]  flg;
        logic        res_we;
        logic        flg_ok;
    } ref_t;

    function automatic ref_t ref_op(input logic [3:0] o, input logic [15:0] x,
                                    input logic [15:0] y, input logic cin);
        ref_t   r;
        int     ua, ub, sa, sb, sh, v, full, sfull, ci;
        bit     c, f, l;
        longint p;
        ua = int'(x);
        ub = int'(y);
        sa = int'($signed(x));
        sb = int'($signed(y));
        sh = ub % 16;
        ci = ((o == 4'd8 || o == 4'd9) && cin) ? 1 : 0;
        r.res_we = 1'b1;
        r.flg_ok = 1'b1;
        c = 1'b0; f = 1'b0; l = (sa < sb); v = 0; full = 0; sfull = 0; p = 0;
        case (o)
            4'd0, 4'd8: begin
                full  = ua + ub + ci;
                sfull = sa + sb + ci;
                v     = full;
                c     = (full > 65535);
                f     = (sfull > 32767) || (sfull < -32768);
            end
            4'd1, 4'd9, 4'd10: begin
                full  = ua - ub - ci;
                sfull = sa - sb - ci;
                v     = full;
                c     = (full < 0);
                f     = (sfull > 32767) || (sfull < -32768);
                if (o == 4'd10) r.res_we = 1'b0;
            end
            4'd2:  v = ua & ub;
            4'd3:  v = ua | ub;
            4'd4:  v = ua ^ ub;
            4'd5:  v = ~ua;
            4'd6:  v = ua << sh;
            4'd7:  v = sa >>> sh;
            4'd11: v = ua >> sh;
`ifdef ALU_SEQ_MUL_EN
            4'd12: begin
                p = longint'(ua) * longint'(ub);
                v = int'(p % 65536);
                c = (p > 65535);
                l = 1'b0;
            end
`endif
            default: begin
                v        = 0;
                r.flg_ok = 1'b0;
            end
        endcase
        r.res = v[15:0];
        r.flg = {c, l, f, (v[15:0] == 16'h0), v[15]};
        return r;
    endfunction

    logic [15:0] m_result = '0;
    logic [4:0]  m_flags  = '0;
    logic        m_done   = 1'b0;
    logic        m_busy   = 1'b0;
    int          m_cnt    = 0;
    ref_t        m_pend   = '0;
    logic        m_pend_we = 1'b0;
    ref_t        w_ref;

    assign w_ref = ref_op(op, a, b, m_flags[4]);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_result <= '0;
            m_flags  <= '0;
            m_done   <= 1'b0;
            m_busy   <= 1'b0;
            m_cnt    <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_cnt > 1) begin
                m_cnt <= m_cnt - 1;
            end else if (m_cnt == 1) begin
                m_cnt    <= 0;
                m_busy   <= 1'b0;
                m_done   <= 1'b1;
                m_result <= m_pend.res;
                if (m_pend_we) m_flags <= m_pend.flg;
            end else if (start) begin
                if (MUL_EN && op == 4'd12) begin
                    m_cnt     <= 16;
                    m_busy    <= 1'b1;
                    m_pend    <= w_ref;
                    m_pend_we <= flag_we;
                end else begin
                    m_done <= 1'b1;
                    if (w_ref.res_we) m_result <= w_ref.res;
                    if (flag_we && w_ref.flg_ok) m_flags <= w_ref.flg;
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(posedge clk or posedge reset) begin
        #1;
        if (checking) begin
            chk("cyc_done",   done,   m_done);
            chk("cyc_busy",   busy,   m_busy);
            chk("cyc_result", result, m_result);
            chk("cyc_flags",  flags,  m_flags);
        end
    end

    //--------------------------------------------------------------------------
    // Stimulus
    //--------------------------------------------------------------------------
    typedef struct packed {
        logic [3:0]  o;
        logic [15:0] x;
        logic [15:0] y;
        logic        w;
    } vec_t;

    vec_t tbl [0:15] = '{
        '{4'd6,  16'h0001, 16'h0014, 1'b1},
        '{4'd11, 16'hF000, 16'h0004, 1'b1},
        '{4'd2,  16'hF0F0, 16'hFF00, 1'b1},
        '{4'd3,  16'hF0F0, 16'h0F0F, 1'b1},
        '{4'd4,  16'hAAAA, 16'hAAAA, 1'b1},
        '{4'd5,  16'h00FF, 16'h0000, 1'b1},
        '{4'd0,  16'hFFFF, 16'h0001, 1'b1},
        '{4'd9,  16'h0005, 16'h0002, 1'b1},
        '{4'd9,  16'h0000, 16'h0000, 1'b1},
        '{4'd8,  16'h8000, 16'h8000, 1'b1},
        '{4'd8,  16'h0001, 16'h0001, 1'b1},
        '{4'd13, 16'h1234, 16'h5678, 1'b1},
        '{4'd15, 16'h1111, 16'h2222, 1'b1},
        '{4'd1,  16'h0000, 16'h0000, 1'b1},
        '{4'd7,  16'h7FFF, 16'h000F, 1'b1},
        '{4'd6,  16'hFFFF, 16'h0010, 1'b1}
    };

    // Call at a falling edge; returns one falling edge later.
    task automatic op1(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                       input logic w);
        start = 1'b1; op = o; a = x; b = y; flag_we = w;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic mul_run(input logic [15:0] x, input logic [15:0] y, input logic w,
                           input bit inject, output int lat);
        op1(4'd12, x, y, w);
        chk("mul_busy_start", busy, 1'b1);
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (inject && lat == 3) begin
                start = 1'b1; op = 4'd0; a = 16'h0001; b = 16'h0001; flag_we = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
    endtask

    initial begin
        int lat;
        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; flag_we = 1'b0;
        repeat (3) @(negedge clk);
        checking = 1'b1;
        chk("rst_busy",   busy,   1'b0);
        chk("rst_done",   done,   1'b0);
        chk("rst_result", result, 16'h0000);
        chk("rst_flags",  flags,  5'b00000);
        reset = 1'b0;

        op1(4'd0, 16'h7FFF, 16'h0001, 1'b1);
        chk("add_ovf_done",   done,   1'b1);
        chk("add_ovf_result", result, 16'h8000);
        chk("add_ovf_flags",  flags,  5'b00101);

        op1(4'd1, 16'h0003, 16'h0005, 1'b1);
        chk("sub_result", result, 16'hFFFE);
        chk("sub_flags",  flags,  5'b11001);
        op1(4'd10, 16'h0005, 16'h0005, 1'b1);
        chk("cmp_result", result, 16'hFFFE);
        chk("cmp_flags",  flags,  5'b00010);

        op1(4'd0, 16'hFFFF, 16'h0001, 1'b1);
        chk("add_carry_result", result, 16'h0000);
        chk("add_carry_flags",  flags,  5'b11010);
        op1(4'd8, 16'h0000, 16'h0000, 1'b0);
        chk("addc_nowe_result", result, 16'h0001);
        chk("addc_nowe_flags",  flags,  5'b11010);
        op1(4'd8, 16'h0000, 16'h0000, 1'b1);
        chk("addc_we_result", result, 16'h0001);
        chk("addc_we_flags",  flags,  5'b00000);

        op1(4'd1, 16'h8000, 16'h0001, 1'b1);
        chk("sub_ovf_result", result, 16'h7FFF);
        chk("sub_ovf_flags",  flags,  5'b01100);

        op1(4'd7, 16'h8000, 16'h0013, 1'b1);
        chk("ash_result", result, 16'hF000);
        chk("ash_flags",  flags,  5'b01001);
        op1(4'hE, 16'h1234, 16'h4321, 1'b1);
        chk("rsv_done",   done,   1'b1);
        chk("rsv_result", result, 16'h0000);
        chk("rsv_flags",  flags,  5'b01001);

        for (int i = 0; i < 16; i++) begin
            op1(tbl[i].o, tbl[i].x, tbl[i].y, tbl[i].w);
        end
        chk("lsh_shamt0_result", result, 16'hFFFF);
        repeat (2) @(negedge clk);

`ifdef ALU_SEQ_MUL_EN
        mul_run(16'h0100, 16'h0100, 1'b1, 1'b1, lat);
        chk("mul_latency", lat,    16);
        chk("mul_result",  result, 16'h0000);
        chk("mul_flags",   flags,  5'b10010);
        op1(4'd0, 16'h0002, 16'h0003, 1'b1);
        chk("start_on_done_result", result, 16'h0005);
        mul_run(16'h1234, 16'h0003, 1'b1, 1'b0, lat);
        chk("mul2_result", result, 16'h369C);
        chk("mul2_flags",  flags,  5'b00000);
        mul_run(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, lat);
        chk("mul3_result", result, 16'h0001);
        chk("mul3_flags",  flags,  5'b00000);
        op1(4'd12, 16'h00FF, 16'h0003, 1'b1);
        repeat (4) @(negedge clk);
`else
        op1(4'd12, 16'h0100, 16'h0100, 1'b1);
        chk("mul_rsv_done",   done,   1'b1);
        chk("mul_rsv_busy",   busy,   1'b0);
        chk("mul_rsv_result", result, 16'h0000);
        op1(4'd1, 16'h0003, 16'h0005, 1'b1);
        repeat (2) @(negedge clk);
`endif
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_busy",   busy,   1'b0);
        chk("mid_rst_done",   done,   1'b0);
        chk("mid_rst_result", result, 16'h0000);
        chk("mid_rst_flags",  flags,  5'b00000);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        op1(4'd0, 16'h0002, 16'h0003, 1'b1);
        chk("post_rst_done",   done,   1'b1);
        chk("post_rst_result", result, 16'h0005);
        repeat (25) @(negedge clk);

        checking = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        n_bad++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter DATA_WIDTH, default 16, operand/result width; SHALL be >= 4.
REQ-002 Parameter SHAMT_W, default $clog2(DATA_WIDTH), shift-amount width taken from b[SHAMT_W-1:0].
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  request; sampled on clk edge when accepted.
REQ-006 op  in  4  opcode (REQ-011).
REQ-007 a, b  in  DATA_WIDTH each  operands, sampled with start.
REQ-008 flag_we  in  1  sampled with start; 1 = commit flags at completion.
REQ-009 busy  out  1  high while a multi-cycle op runs; start ignored while high.
REQ-010 done  out  1  one-cycle pulse when result/flags update; result  out  DATA_WIDTH  held until next done; flags  out  5  {C,L,F,Z,N} register.

Function
REQ-011 Opcodes SHALL be: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT a, 6 LSH (logical left), 7 ASH (arithmetic right), 8 ADDC (a+b+C), 9 SUBC (a-b-C), 10 CMP (flags as SUB, result unchanged), 11 LSR (logical right), 12 MUL, 13-15 reserved.
REQ-012 FSM states SHALL be IDLE and MUL; start in IDLE with op 12 -> MUL; all other ops stay IDLE.
REQ-013 Single-cycle ops: start accepted at edge n -> result/flags registered, done=1 during cycle n+1; back-to-back start every cycle allowed.
REQ-014 MUL: unsigned shift-add, one bit per cycle, DATA_WIDTH iterations; done=1 exactly DATA_WIDTH+1 cycles after accepting edge; MUL -> IDLE on the same edge done rises.
REQ-015 start in the cycle done is high (IDLE) SHALL be accepted.
REQ-016 ADD/ADDC: C = carry-out; F = signed overflow (operands same sign, result sign differs).
REQ-017 SUB/SUBC/CMP: C = unsigned borrow; F = signed overflow (operands differ in sign, result sign differs from a).
REQ-018 Logic and shift ops: C=0, F=0.
REQ-019 All ops except MUL: L = signed(a) < signed(b); N = result MSB; Z = (result == 0); CMP uses a-b as result for Z/N.
REQ-020 MUL: result = low DATA_WIDTH bits of product; C = (upper half != 0); L=F=0; Z,N from low half.
REQ-021 ADDC/SUBC SHALL use C from flags register at the accepting edge.
REQ-022 Shift amount = b[SHAMT_W-1:0]; upper bits of b ignored.
REQ-023 flags SHALL update only on done with captured flag_we=1; otherwise held.
REQ-024 Reserved ops: result=0, flags unchanged, done next cycle.

Reset
REQ-025 reset SHALL immediately force IDLE, busy=0, done=0, result=0, flags=0, multiplier state cleared, including mid-MUL.
REQ-026 First start after reset release SHALL be accepted at the first rising edge with reset low.

Configuration
REQ-027 Macro ALU_SEQ_MUL_EN defined: MUL per REQ-014/020.
REQ-028 Macro undefined: op 12 treated as reserved (REQ-024), no multiplier datapath, busy tied 0.

Structure
REQ-029 Shared package alu_pkg SHALL hold opcode enum/localparams, flag bit indices (C=4,L=3,F=2,Z=1,N=0) and FSM state encoding.
REQ-030 Iterative multiplier SHALL be sub-module alu_mul_iter (start, a, b -> product, done); remaining datapath inline.

Verification (DATA_WIDTH=16)
REQ-031 ADD a=0x7FFF b=0x0001 flag_we=1 -> next cycle done=1, result=0x8000, C=0 L=0 F=1 Z=0 N=1.
REQ-032 SUB a=0x0003 b=0x0005 -> result=0xFFFE, C=1 L=1 F=0 Z=0 N=1; then CMP a=5 b=5 -> result still 0xFFFE, Z=1.
REQ-033 ADD 0xFFFF+0x0001 (result 0, C=1, Z=1), then ADDC 0x0000+0x0000 -> result=0x0001, C=0; ADDC with flag_we=0 leaves flags C=1.
REQ-034 MUL 0x0100*0x0100 -> busy high 16 cycles, done 17 cycles after start, result=0x0000, C=1 Z=1; start mid-MUL ignored.
REQ-035 reset asserted 5 cycles into MUL -> same cycle busy=0, done=0, result=0, flags=0; no later done.
REQ-036 ASH a=0x8000 b=0x0013 -> result=0xF000; op 0xE -> result=0, flags unchanged, done=1.
